// File: rtl/countdown_if.sv
// Control and status bundle for the countdown timer.
// The master side drives the commands and presets; the slave side returns the time and status.
interface countdown_if;
    logic        load;
    logic [3:0]  preset_min;
    logic [7:0]  preset_sec;
    logic        start;
    logic        pause;
    logic        ack;
    logic [11:0] counter_ms;
    logic [7:0]  counter_sec;
    logic [3:0]  counter_min;
    logic        running;
    logic        done;
    logic        alarm;

    modport master (
        output load, preset_min, preset_sec, start, pause, ack,
        input  counter_ms, counter_sec, counter_min, running, done, alarm
    );

    modport slave (
        input  load, preset_min, preset_sec, start, pause, ack,
        output counter_ms, counter_sec, counter_min, running, done, alarm
    );
endinterface

// File: rtl/countdown_timer.sv
// Minutes:seconds.milliseconds countdown timer with pause, expiry pulse and a latched alarm.
// A 16-bit prescaler turns CLK_PER_MS clock cycles into one millisecond tick.
module countdown_timer #(
    parameter int CLK_PER_MS = 50000
) (
    input  logic        clk,
    input  logic        rst,
    countdown_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    localparam logic [15:0] PRESC_MAX = 16'(CLK_PER_MS - 1);

    state_t      state, state_n;
    logic [15:0] presc, presc_n;
    logic [11:0] ms_cnt, ms_n;
    logic [7:0]  sec_cnt, sec_n;
    logic [3:0]  min_cnt, min_n;
    logic        done_q, done_n;
    logic        running_q, running_n;
    logic        alarm_q, alarm_n;
    logic        tick;
    logic        time_zero;

    assign time_zero = (ms_cnt == 12'd0) && (sec_cnt == 8'd0) && (min_cnt == 4'd0);

    // NOTE: every flop is cleared here, including the countdown registers, so no X ever reaches the outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            presc     <= '0;
            ms_cnt    <= '0;
            sec_cnt   <= '0;
            min_cnt   <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
            state     <= state_n;
            presc     <= presc_n;
            ms_cnt    <= ms_n;
            sec_cnt   <= sec_n;
            min_cnt   <= min_n;
            done_q    <= done_n;
            running_q <= running_n;
            alarm_q   <= alarm_n;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_n = state;
        presc_n = presc;
        ms_n    = ms_cnt;
        sec_n   = sec_cnt;
        min_n   = min_cnt;
        done_n  = 1'b0;
        tick    = 1'b0;

        if (bus.load) begin
            min_n   = (bus.preset_min > 4'd9)  ? 4'd9  : bus.preset_min;
            sec_n   = (bus.preset_sec > 8'd59) ? 8'd59 : bus.preset_sec;
            ms_n    = 12'd0;
            presc_n = 16'd0;
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (bus.start && !time_zero) state_n = bus.pause ? HOLD : RUN;
                RUN: begin
                    if (bus.pause) begin
                        state_n = HOLD;
                    end else if (presc == PRESC_MAX) begin
                        presc_n = 16'd0;
                        tick    = 1'b1;
                    end else begin
                        presc_n = presc + 16'd1;
                    end
                end
                HOLD:    if (!bus.pause) state_n = RUN;
                DONE:    if (bus.ack) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end

        // Borrow chain ms -> sec -> min; RUN always holds a non-zero time, so min never underflows.
        if (tick) begin
            if (ms_cnt != 12'd0) begin
                ms_n = ms_cnt - 12'd1;
            end else begin
                ms_n = 12'd999;
                if (sec_cnt != 8'd0) begin
                    sec_n = sec_cnt - 8'd1;
                end else begin
                    sec_n = 8'd59;
                    min_n = min_cnt - 4'd1;
                end
            end
            if (ms_cnt == 12'd1 && sec_cnt == 8'd0 && min_cnt == 4'd0) begin
                state_n = DONE;
                done_n  = 1'b1;
            end
        end
    end

    always_comb begin
        running_n = (state_n == RUN);
        alarm_n   = (state_n == DONE);
    end

    assign bus.counter_ms  = ms_cnt;
    assign bus.counter_sec = sec_cnt;
    assign bus.counter_min = min_cnt;
    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.alarm       = alarm_q;

endmodule
